// File: rtl/adder_pkg.sv
// Shared types and lookahead helper for the 32-bit adder datapath.
package adder_pkg;

  localparam int ADDER_GROUP_W = 4;

  typedef logic [31:0] word_t;

  // Carries out of each bit of a 4-bit group, all computed straight from g/p and the group carry-in.
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

endpackage

// File: rtl/full_adder_1b.sv
// Single-bit adder cell exposing generate/propagate for the group lookahead.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic g,
  output logic p
);

  assign g = a & b;
  assign p = a ^ b;
  assign s = p ^ cin;

endmodule

// File: rtl/full_adder_32b.sv
// Registered unsigned adder: 4-bit lookahead groups rippled together, one-cycle latency.
module full_adder_32b
  import adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int NGRP = WIDTH / ADDER_GROUP_W;

  logic [WIDTH-1:0] g_w, p_w, s_w, cin_w;
  logic             carry_d;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_q;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    full_adder_1b u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .cin(cin_w[i]),
      .s  (s_w[i]),
      .g  (g_w[i]),
      .p  (p_w[i])
    );
  end

  for (genvar k = 0; k < NGRP; k++) begin : gen_grp
    logic       ci;
    logic [3:0] c;
    if (k == 0) begin : gen_first
      assign ci = 1'b0;
    end else begin : gen_rest
      assign ci = gen_grp[k-1].c[3];
    end
    assign c = cla4(g_w[k*4 +: 4], p_w[k*4 +: 4], ci);
    assign cin_w[k*4 +: 4] = {c[2:0], ci};
  end

  assign sum_d   = s_w;
  assign carry_d = gen_grp[NGRP-1].c[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_full_adder_32b.sv
// Self-checking bench for full_adder_32b against a 33-bit arithmetic reference.
module tb_full_adder_32b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [31:0] sum;
  logic        carry;

  int errs = 0;
  int checks = 0;

  full_adder_32b #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .sum  (sum),
    .carry(carry)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got carry=%0b sum=%08h, want carry=%0b sum=%08h",
               tag, obs[32], obs[31:0], exp[32], exp[31:0]);
    end
  endtask

  // Present operands after a falling edge, then check one step past the next rising edge.
  task automatic step(input string tag, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a = x;
    b = y;
    @(posedge clk);
    #1;
    chk(tag, {carry, sum}, ref_add(x, y));
  endtask

  logic [32:0] expq[$];
  logic [32:0] held;

  initial begin
    #2;
    chk("reset_initial", {carry, sum}, 33'h0);
    @(negedge clk);
    rst = 1'b0;

    step("zero", 32'h0, 32'h0);
    step("simple", 32'h12345678, 32'h87654321);
    step("wrap_one", 32'hFFFFFFFF, 32'h00000001);
    chk("wrap_one_const", {carry, sum}, {1'b1, 32'h0});
    step("all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("all_ones_const", {carry, sum}, {1'b1, 32'hFFFFFFFE});
    step("grp_ripple", 32'h0000FFFF, 32'h00000001);
    chk("grp_ripple_const", {carry, sum}, {1'b0, 32'h00010000});
    step("msb_msb", 32'h80000000, 32'h80000000);
    for (int k = 0; k < 8; k++)
      step("grp_boundary", 32'hFFFFFFFF >> (4 * k), 32'h1 << (4 * k));

    // Async reset mid-cycle: outputs must clear with no clock edge.
    step("pre_reset", 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    a = 32'h12345678;
    b = 32'h00000001;
    #1;
    rst = 1'b1;
    #1;
    chk("reset_async", {carry, sum}, 33'h0);
    @(posedge clk);
    #1;
    chk("reset_hold", {carry, sum}, 33'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_release", {carry, sum}, {1'b0, 32'h12345679});

    // Inputs changing between edges must not reach the outputs.
    step("latency_base", 32'h00000010, 32'h00000020);
    held = {carry, sum};
    @(negedge clk);
    a = 32'hDEADBEEF;
    b = 32'hCAFEF00D;
    #2;
    chk("latency_hold", {carry, sum}, held);
    @(posedge clk);
    #1;
    chk("latency_update", {carry, sum}, ref_add(32'hDEADBEEF, 32'hCAFEF00D));

    // Back-to-back operands, one per cycle, each result exactly one edge later.
    for (int k = 0; k < 10; k++) begin
      logic [31:0] x, y;
      x = (k == 0) ? 32'h0 : $urandom;
      y = (k == 0) ? 32'h0 : $urandom;
      @(negedge clk);
      a = x;
      b = y;
      expq.push_back(ref_add(x, y));
      @(posedge clk);
      #1;
      chk("b2b", {carry, sum}, expq.pop_front());
    end

    for (int k = 0; k < 200; k++)
      step("random", $urandom, $urandom);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
